// File: rtl/bcam_mbist_outhandler.sv
// BCAM MBIST output handler: delays accepted compares, checks the returned match vector,
// and keeps pulse/sticky/first-fail results. Define BCAM_MBIST_FAIL_CNT_EN to build the fail counter.
module bcam_mbist_outhandler #(
    parameter int RF_DEPTH      = 64,
    parameter int AWIDTH        = 6,
    parameter int CM_RD_LATENCY = 1,
    parameter int FAIL_CNT_W    = 8
) (
    input  logic                  bist_clk,
    input  logic                  rst_b,
    input  logic                  BIST_CM_MODE_RF_IN,
    input  logic                  BIST_CM_COMPARE_EN_RF_IN,
    input  logic [AWIDTH-1:0]     BIST_EXP_ADDR_RF_IN,
    input  logic                  BIST_EXP_HIT_RF_IN,
    input  logic [RF_DEPTH-1:0]   CM_MATCH_RF_IN,
    input  logic                  BIST_CLEAR_RF_IN,
    output logic                  BIST_CM_FAIL_PULSE_RF_OUT,
    output logic                  BIST_CM_FAIL_RF_OUT,
    output logic [FAIL_CNT_W-1:0] BIST_CM_FAIL_CNT_RF_OUT,
    output logic [AWIDTH-1:0]     BIST_CM_FIRST_FAIL_ADDR_RF_OUT,
    output logic                  BIST_CM_FIRST_FAIL_MULTI_RF_OUT,
    output logic                  BIST_CM_BUSY_RF_OUT
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FAILED} state_t;

    state_t                   state, state_nxt;
    logic                     vld_p0;
    logic [CM_RD_LATENCY-1:0] vld_p1;
    logic [AWIDTH-1:0]        addr_p1 [CM_RD_LATENCY];
    logic [CM_RD_LATENCY-1:0] hit_p1;
    logic                     vld_p2;
    logic                     fail_p2;
    logic                     chk_vld, chk_fail, chk_multi;
    logic [AWIDTH-1:0]        chk_addr;
    logic [RF_DEPTH-1:0]      chk_exp;

    function automatic logic [RF_DEPTH-1:0] expected_vec(input logic [AWIDTH-1:0] addr,
                                                         input logic hit);
        logic [RF_DEPTH-1:0] v;
        v = '0;
        if (hit) v[addr] = 1'b1;
        return v;
    endfunction

    function automatic logic more_than_one(input logic [RF_DEPTH-1:0] m);
        return |(m & (m - RF_DEPTH'(1)));
    endfunction

    // Issue stage: a compare only counts while the array is in CAM test mode
    assign vld_p0 = BIST_CM_COMPARE_EN_RF_IN & BIST_CM_MODE_RF_IN;

    always_ff @(posedge bist_clk or negedge rst_b) begin
        if (!rst_b) begin
            vld_p1 <= '0;
        end else if (BIST_CLEAR_RF_IN) begin
            vld_p1 <= '0;
        end else begin
            vld_p1[0] <= vld_p0;
            for (int i = 1; i < CM_RD_LATENCY; i++) vld_p1[i] <= vld_p1[i-1];
        end
    end

    always_ff @(posedge bist_clk) begin
        addr_p1[0] <= BIST_EXP_ADDR_RF_IN;
        hit_p1[0]  <= BIST_EXP_HIT_RF_IN;
        for (int i = 1; i < CM_RD_LATENCY; i++) begin
            addr_p1[i] <= addr_p1[i-1];
            hit_p1[i]  <= hit_p1[i-1];
        end
    end

    // Check stage: the match vector arrives in the same cycle the delayed compare emerges
    assign chk_vld   = vld_p1[CM_RD_LATENCY-1];
    assign chk_addr  = addr_p1[CM_RD_LATENCY-1];
    assign chk_exp   = expected_vec(chk_addr, hit_p1[CM_RD_LATENCY-1]);
    assign chk_fail  = chk_vld & (CM_MATCH_RF_IN != chk_exp);
    assign chk_multi = more_than_one(CM_MATCH_RF_IN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (BIST_CM_MODE_RF_IN) state_nxt = ACTIVE;
            ACTIVE: begin
                if (chk_fail)                                  state_nxt = FAILED;
                else if (!BIST_CM_MODE_RF_IN && !(|vld_p1))    state_nxt = IDLE;
            end
            FAILED:  state_nxt = FAILED;
            default: state_nxt = IDLE;
        endcase
        if (BIST_CLEAR_RF_IN) state_nxt = IDLE;
    end

    // Result stage: clear suppresses a fail landing on the same edge
    always_ff @(posedge bist_clk or negedge rst_b) begin
        if (!rst_b) begin
            state                           <= IDLE;
            vld_p2                          <= 1'b0;
            fail_p2                         <= 1'b0;
            BIST_CM_FIRST_FAIL_ADDR_RF_OUT  <= '0;
            BIST_CM_FIRST_FAIL_MULTI_RF_OUT <= 1'b0;
        end else begin
            state   <= state_nxt;
            vld_p2  <= chk_vld & ~BIST_CLEAR_RF_IN;
            fail_p2 <= chk_fail & ~BIST_CLEAR_RF_IN;
            if (BIST_CLEAR_RF_IN) begin
                BIST_CM_FIRST_FAIL_ADDR_RF_OUT  <= '0;
                BIST_CM_FIRST_FAIL_MULTI_RF_OUT <= 1'b0;
            end else if (state == ACTIVE && chk_fail) begin
                BIST_CM_FIRST_FAIL_ADDR_RF_OUT  <= chk_addr;
                BIST_CM_FIRST_FAIL_MULTI_RF_OUT <= chk_multi;
            end
        end
    end

`ifdef BCAM_MBIST_FAIL_CNT_EN
    logic [FAIL_CNT_W-1:0] fail_cnt_p2;

    function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] c);
        return (c == '1) ? c : c + FAIL_CNT_W'(1);
    endfunction

    always_ff @(posedge bist_clk or negedge rst_b) begin
        if (!rst_b)                fail_cnt_p2 <= '0;
        else if (BIST_CLEAR_RF_IN) fail_cnt_p2 <= '0;
        else if (chk_fail)         fail_cnt_p2 <= sat_inc(fail_cnt_p2);
    end

    assign BIST_CM_FAIL_CNT_RF_OUT = fail_cnt_p2;
`else
    assign BIST_CM_FAIL_CNT_RF_OUT = '0;
`endif

    assign BIST_CM_FAIL_PULSE_RF_OUT = fail_p2;
    assign BIST_CM_FAIL_RF_OUT       = (state == FAILED);
    assign BIST_CM_BUSY_RF_OUT       = (|vld_p1) | vld_p2;

endmodule

// File: doc/bcam_mbist_outhandler.md
BCAM_MBIST_OUTHANDLER -- requirements
Module: bcam_mbist_outhandler

Interface
REQ-001 Parameters SHALL be: RF_DEPTH, default 64, number of CAM entries; AWIDTH, default 6, entry address width (clog2 RF_DEPTH); CM_RD_LATENCY, default 1, cycles from compare issue to match vector valid (legal range 1..4); FAIL_CNT_W, default 8, fail counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- bist_clk  in  1  single clock.
- rst_b  in  1  asynchronous active-low reset.
- BIST_CM_MODE_RF_IN  in  1  CAM test mode from MBIST.
- BIST_CM_COMPARE_EN_RF_IN  in  1  compare issued to array this cycle.
- BIST_EXP_ADDR_RF_IN  in  AWIDTH  expected hit entry.
- BIST_EXP_HIT_RF_IN  in  1  1 = expect hit at EXP_ADDR only; 0 = expect no hit.
- CM_MATCH_RF_IN  in  RF_DEPTH  match vector from array.
- BIST_CLEAR_RF_IN  in  1  synchronous clear of results.
- BIST_CM_FAIL_PULSE_RF_OUT  out  1  per-compare fail strobe.
- BIST_CM_FAIL_RF_OUT  out  1  sticky fail.
- BIST_CM_FAIL_CNT_RF_OUT  out  FAIL_CNT_W  saturating fail count.
- BIST_CM_FIRST_FAIL_ADDR_RF_OUT  out  AWIDTH  expected address of first failing compare.
- BIST_CM_FIRST_FAIL_MULTI_RF_OUT  out  1  first fail had more than one match bit set.
- BIST_CM_BUSY_RF_OUT  out  1  compares in flight.

Function
REQ-003 Compare SHALL be accepted at cycle T only when BIST_CM_COMPARE_EN_RF_IN=1 and BIST_CM_MODE_RF_IN=1; otherwise ignored.
REQ-004 Accepted {valid, EXP_ADDR, EXP_HIT} SHALL be delayed by a CM_RD_LATENCY-deep shift pipeline and checked against CM_MATCH_RF_IN sampled at T+CM_RD_LATENCY.
REQ-005 Fail condition SHALL be: EXP_HIT=1 and match != one-hot(EXP_ADDR); or EXP_HIT=0 and match != 0.
REQ-006 BIST_CM_FAIL_PULSE_RF_OUT SHALL be registered, high for exactly one cycle at T+CM_RD_LATENCY+1 for each failing compare.
REQ-007 FSM states SHALL be IDLE, ACTIVE, FAILED: IDLE->ACTIVE when CM_MODE=1; ACTIVE->FAILED on first fail; ACTIVE->IDLE when CM_MODE=0 and pipeline empty; FAILED held until clear or reset.
REQ-008 On the ACTIVE->FAILED transition, FIRST_FAIL_ADDR and FIRST_FAIL_MULTI SHALL capture and then hold; later fails SHALL NOT overwrite them.
REQ-009 Sticky BIST_CM_FAIL_RF_OUT SHALL be high in FAILED state only.
REQ-010 Fail counter SHALL increment by 1 per failing compare and saturate at all-ones.
REQ-011 Compares in flight when CM_MODE drops SHALL still be checked and reported.
REQ-012 BIST_CM_BUSY_RF_OUT SHALL be high while any pipeline valid bit or the result-stage valid bit is set.
REQ-013 BIST_CLEAR_RF_IN SHALL, next edge: flush pipeline valids, zero count, sticky and capture registers, FSM->IDLE; clear wins over a same-cycle fail.
REQ-014 Back-to-back compares every cycle SHALL be supported with no bubbles.

Reset
REQ-015 rst_b low SHALL asynchronously force all outputs, pipeline valids and capture registers to 0 and FSM to IDLE; deassertion takes effect on the next bist_clk edge.
REQ-016 Reset mid-operation SHALL discard all in-flight compares without reporting them.

Configuration
REQ-017 Macro BCAM_MBIST_FAIL_CNT_EN SHALL, when defined, compile in the fail counter; when undefined, BIST_CM_FAIL_CNT_RF_OUT SHALL be tied to 0 and no counter flops built, all other behaviour unchanged.

Verification
REQ-018 Write-hit: EXP_HIT=1, EXP_ADDR=5, match=0x20 at T+1 -> no pulse, FAIL=0, CNT=0.
REQ-019 Wrong hit: EXP_ADDR=5, match=0x40 -> pulse at T+2, FAIL=1, FIRST_FAIL_ADDR=5, MULTI=0, CNT=1.
REQ-020 Masked miss: EXP_HIT=0, match=0x0 -> pass; then match=0x3 at EXP_ADDR=9 -> FIRST_FAIL_ADDR=9, MULTI=1.
REQ-021 Saturation: 300 consecutive failing compares with FAIL_CNT_W=8 -> CNT=255, FIRST_FAIL_ADDR from first compare only; with macro undefined, CNT=0.
REQ-022 Clear/fail collision: CLEAR asserted same cycle as a failing result -> FAIL=0, CNT=0, FSM=IDLE next cycle.
REQ-023 Async reset with CM_RD_LATENCY=3 and 3 compares in flight -> outputs 0 immediately, BUSY=0, no pulses after release.
